// File: rtl/sort_unit.sv
// Streaming packet sorter: parallel insertion into a sorted register array, then
// in-order replay with fresh framing. Define SORT_DESCENDING_EN for non-increasing output.
module sort_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LENGTH = 128
) (
    input  logic                  snk_clock,
    input  logic                  snk_reset,
    output logic                  snk_ready,
    input  logic                  snk_valid,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    input  logic [DATA_WIDTH-1:0] snk_data,
    output logic                  src_valid,
    output logic                  src_sop,
    output logic                  src_eop,
    output logic [DATA_WIDTH-1:0] src_data
);

    localparam int unsigned AW = $clog2(MAX_LENGTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DROP,
        S_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         rd_q, rd_d;
    logic [DATA_WIDTH-1:0] mem_q    [MAX_LENGTH];
    logic [DATA_WIDTH-1:0] mem_sh   [MAX_LENGTH];
    logic [DATA_WIDTH-1:0] ins_word [MAX_LENGTH];
    logic [MAX_LENGTH-1:0] le;
    logic [MAX_LENGTH-1:0] le_prev;
    logic [CW-1:0]         n_base;
    logic                  clr;
    logic                  ins_en;
    logic                  accept;
    logic                  src_valid_q, src_valid_d;
    logic                  src_sop_q, src_sop_d;
    logic                  src_eop_q, src_eop_d;
    logic [DATA_WIDTH-1:0] src_data_q, src_data_d;

    assign snk_ready = (state_q != S_OUTPUT);
    assign accept    = snk_valid && snk_ready;

    assign src_valid = src_valid_q;
    assign src_sop   = src_sop_q;
    assign src_eop   = src_eop_q;
    assign src_data  = src_data_q;

    // le[i]: stored entry i stays put; the new word lands at the first position
    // whose predecessor stays put, everything after it shifts up by one.
    always_comb begin
        n_base = clr ? '0 : n_q;
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
`ifdef SORT_DESCENDING_EN
            le[i] = (CW'(i) < n_base) && (mem_q[i] >= snk_data);
`else
            le[i] = (CW'(i) < n_base) && (mem_q[i] <= snk_data);
`endif
        end
        le_prev   = {le[MAX_LENGTH-2:0], 1'b1};
        mem_sh[0] = snk_data;
        for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
            mem_sh[i] = mem_q[i-1];
        end
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            if (le[i]) begin
                ins_word[i] = mem_q[i];
            end else if (le_prev[i]) begin
                ins_word[i] = snk_data;
            end else begin
                ins_word[i] = mem_sh[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_d        = rd_q;
        clr         = 1'b0;
        ins_en      = 1'b0;
        src_valid_d = 1'b0;
        src_sop_d   = 1'b0;
        src_eop_d   = 1'b0;
        src_data_d  = '0;

        case (state_q)
            S_IDLE, S_LOAD, S_DROP: begin
                if (accept) begin
                    if (snk_sop) begin
                        clr    = 1'b1;
                        ins_en = 1'b1;
                    end else if (state_q == S_LOAD) begin
                        ins_en = 1'b1;
                    end

                    if (ins_en) begin
                        n_d = (snk_sop ? '0 : n_q) + CW'(1);
                        if (snk_eop) begin
                            state_d = S_OUTPUT;
                            rd_d    = '0;
                        end else if (n_d == CW'(MAX_LENGTH)) begin
                            state_d = S_DROP;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else if (state_q == S_DROP && snk_eop) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_OUTPUT: begin
                // One extra cycle after the last word keeps ready low until the
                // source registers have drained.
                if (rd_q < n_q) begin
                    src_valid_d = 1'b1;
                    src_sop_d   = (rd_q == '0);
                    src_eop_d   = (rd_q == n_q - CW'(1));
                    src_data_d  = mem_q[rd_q[AW-1:0]];
                    rd_d        = rd_q + CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge snk_clock or posedge snk_reset) begin
        if (snk_reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            rd_q        <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_q        <= rd_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_data_q  <= src_data_d;
        end
    end

    always_ff @(posedge snk_clock) begin
        if (ins_en) begin
            mem_q <= ins_word;
        end
    end

endmodule

// File: tb/tb_sort_unit.sv
// Randomized bench for sort_unit: a packet-level queue model predicts every
// cycle's snk_ready and src_* values, including latency and overflow drops.
module tb_sort_unit;

    localparam int DW = 16;
    localparam int ML = 128;

    typedef logic [DW-1:0] wq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          snk_ready;
    logic          snk_valid;
    logic          snk_sop;
    logic          snk_eop;
    logic [DW-1:0] snk_data;
    logic          src_valid;
    logic          src_sop;
    logic          src_eop;
    logic [DW-1:0] src_data;

    sort_unit #(.DATA_WIDTH(DW), .MAX_LENGTH(ML)) dut (
        .snk_clock(clk),
        .snk_reset(rst),
        .snk_ready(snk_ready),
        .snk_valid(snk_valid),
        .snk_sop(snk_sop),
        .snk_eop(snk_eop),
        .snk_data(snk_data),
        .src_valid(src_valid),
        .src_sop(src_sop),
        .src_eop(src_eop),
        .src_data(src_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] pkt[$];
    logic [DW-1:0] outq[$];
    bit            active = 1'b0;
    int            k_eop  = -1000;
    int            n_out  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Block is busy from the eop edge through the edge that emits the last word.
    function automatic bit model_ready();
        return !(cyc >= k_eop && cyc <= k_eop + n_out);
    endfunction

    task automatic model_accept(input logic sop, input logic eop, input logic [DW-1:0] d);
        if (sop) begin
            pkt.delete();
            active = 1'b1;
        end
        if (active) pkt.push_back(d);
        if (eop && active) begin
            active = 1'b0;
            if (pkt.size() <= ML) begin
`ifdef SORT_DESCENDING_EN
                pkt.rsort();
`else
                pkt.sort();
`endif
                outq  = pkt;
                k_eop = cyc;
                n_out = pkt.size();
            end
        end
    endtask

    task automatic model_reset();
        pkt.delete();
        outq.delete();
        active = 1'b0;
        k_eop  = -1000;
        n_out  = 0;
    endtask

    task automatic check_outputs();
        logic [DW+2:0] e;
        int j;
        e = '0;
        if (cyc >= k_eop + 1 && cyc <= k_eop + n_out) begin
            j = cyc - k_eop - 1;
            e = {1'b1, (j == 0), (j == n_out - 1), outq[j]};
        end
        check("snk_ready", 32'(snk_ready), 32'(model_ready()));
        check("src{v,sop,eop,data}", 32'({src_valid, src_sop, src_eop, src_data}), 32'(e));
    endtask

    task automatic step(input logic v, input logic sop, input logic eop, input logic [DW-1:0] d);
        bit rdy;
        rdy       = model_ready();
        snk_valid = v;
        snk_sop   = sop;
        snk_eop   = eop;
        snk_data  = d;
        @(posedge clk);
        cyc++;
        if (v && rdy) model_accept(sop, eop, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
    endtask

    task automatic send_word(input logic sop, input logic eop, input logic [DW-1:0] d);
        int w;
        w = 0;
        // Words offered while busy must be ignored by the block.
        while (!model_ready()) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
            w++;
            if (w > 400) begin
                check("ready_timeout", 32'(0), 32'(1));
                break;
            end
        end
        step(1'b1, sop, eop, d);
    endtask

    task automatic send_packet(input wq_t words, input bit gaps);
        for (int i = 0; i < words.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
            send_word(i == 0, i == words.size() - 1, words[i]);
        end
    endtask

    function automatic wq_t rand_words(input int len, input int maxval);
        wq_t q;
        for (int i = 0; i < len; i++) q.push_back(DW'($urandom_range(0, maxval)));
        return q;
    endfunction

    task automatic drain();
        int w;
        w = 0;
        while (!(model_ready() && cyc > k_eop + n_out)) begin
            idle(1);
            w++;
            if (w > 400) begin
                check("drain_timeout", 32'(0), 32'(1));
                break;
            end
        end
        idle(2);
    endtask

    task automatic reset_now();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        @(posedge clk);
        cyc++;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(snk_ready), 32'(1));
        check("rst_src", 32'({src_valid, src_sop, src_eop, src_data}), '0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("rst_hold_src", 32'({src_valid, src_sop, src_eop, src_data}), '0);
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        wq_t w;
        int  g;
        rst       = 1'b1;
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        snk_data  = '0;
        @(negedge clk);
        check("init_ready", 32'(snk_ready), 32'(1));
        check("init_src", 32'({src_valid, src_sop, src_eop, src_data}), '0);
        rst = 1'b0;
        idle(3);

        // Stray words without sop in idle are dropped.
        step(1'b1, 1'b0, 1'b0, 16'h0AAA);
        step(1'b1, 1'b0, 1'b0, 16'h0BBB);
        step(1'b1, 1'b0, 1'b1, 16'h0CCC);
        idle(3);

        w = '{16'h0005, 16'h0003, 16'hFFFF, 16'h0003, 16'h0000};
        send_packet(w, 1'b0);
        drain();

        w = '{16'h1234};
        send_packet(w, 1'b0);
        drain();

        // Full-length packet followed by back-to-back random packets.
        send_packet(rand_words(ML, 65535), 1'b0);
        for (int p = 0; p < 10; p++) begin
            send_packet(rand_words($urandom_range(2, ML), (p % 3 == 0) ? 7 : 65535), 1'b0);
        end
        drain();

        // sop inside a packet restarts it.
        send_word(1'b1, 1'b0, 16'h7777);
        send_word(1'b0, 1'b0, 16'h6666);
        send_packet(rand_words(4, 65535), 1'b1);
        drain();
        send_packet(rand_words(20, 15), 1'b1);
        drain();

        // Oversized packet is dropped entirely.
        send_packet(rand_words(ML + 2, 65535), 1'b0);
        w = '{16'h0300, 16'h0100, 16'h0200};
        send_packet(w, 1'b0);
        drain();

        // Overflow without eop, then a new sop recovers.
        w = rand_words(ML + 1, 65535);
        for (int i = 0; i < w.size(); i++) send_word(i == 0, 1'b0, w[i]);
        send_packet(rand_words(5, 65535), 1'b0);
        drain();

        // Reset in the middle of output.
        send_packet(rand_words(10, 65535), 1'b0);
        g = 0;
        while (cyc < k_eop + 4 && g < 100) begin
            idle(1);
            g++;
        end
        reset_now();
        idle(3);
        send_packet(rand_words(7, 65535), 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
